// File: rtl/multi_counter.sv
// Bank of independent up/down counters with load, wrap/saturate and sticky overflow,
// plus a snapshot register that captures every channel from the same cycle.
module multi_counter #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int SATURATE = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       i_enable,
    input  logic [CHANNELS-1:0]       i_up_down,
    input  logic [CHANNELS-1:0]       i_load,
    input  logic [CHANNELS*WIDTH-1:0] i_load_value,
    input  logic [CHANNELS-1:0]       i_clear_ovf,
    input  logic                      i_capture,
    output logic [CHANNELS*WIDTH-1:0] o_count_out,
    output logic [CHANNELS-1:0]       o_tc,
    output logic [CHANNELS-1:0]       o_ovf,
    output logic [CHANNELS*WIDTH-1:0] o_capture_out,
    output logic                      o_capture_valid
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]          r_count [CHANNELS];
    logic [WIDTH-1:0]          w_next  [CHANNELS];
    logic [CHANNELS-1:0]       w_event;
    logic [CHANNELS-1:0]       r_tc;
    logic [CHANNELS-1:0]       r_ovf;
    logic [CHANNELS*WIDTH-1:0] w_count_flat;
    logic [CHANNELS*WIDTH-1:0] r_capture;
    logic                      r_capture_valid;

    // A limit event is an enabled step attempted past MAX (up) or below 0 (down);
    // without saturation the modulo add/subtract already produces the wrapped value.
    always_comb begin
        w_next       = r_count;
        w_event      = '0;
        w_count_flat = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_count_flat[i*WIDTH +: WIDTH] = r_count[i];
            if (i_load[i]) begin
                w_next[i] = i_load_value[i*WIDTH +: WIDTH];
            end else if (i_enable[i]) begin
                if (i_up_down[i]) begin
                    w_event[i] = (r_count[i] == MAX);
                    if (!((r_count[i] == MAX) && (SATURATE != 0)))
                        w_next[i] = r_count[i] + ONE;
                end else begin
                    w_event[i] = (r_count[i] == '0);
                    if (!((r_count[i] == '0) && (SATURATE != 0)))
                        w_next[i] = r_count[i] - ONE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) r_count[i] <= '0;
            r_tc            <= '0;
            r_ovf           <= '0;
            r_capture       <= '0;
            r_capture_valid <= 1'b0;
        end else begin
            r_count         <= w_next;
            r_tc            <= w_event;
            // Set beats clear when both land on the same edge.
            r_ovf           <= w_event | (r_ovf & ~i_clear_ovf);
            r_capture_valid <= i_capture;
            if (i_capture) r_capture <= w_count_flat;
        end
    end

    assign o_count_out     = w_count_flat;
    assign o_tc            = r_tc;
    assign o_ovf           = r_ovf;
    assign o_capture_out   = r_capture;
    assign o_capture_valid = r_capture_valid;

endmodule

// File: tb/tb_multi_counter.sv
// Directed bench for multi_counter: a vector table for single-edge behaviour plus
// hand sequences for full-range counting, saturation and reset during activity.
module tb_multi_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] enable, up_down, load, clear_ovf;
    logic [7:0] load_value;
    logic       capture;

    logic [7:0] count_out, capture_out, s_count_out, s_capture_out;
    logic [1:0] tc, ovf, s_tc, s_ovf;
    logic       capture_valid, s_capture_valid;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multi_counter #(.WIDTH(4), .CHANNELS(2), .SATURATE(0)) dut_wrap (
        .clock(clock), .reset(reset), .i_enable(enable), .i_up_down(up_down),
        .i_load(load), .i_load_value(load_value), .i_clear_ovf(clear_ovf),
        .i_capture(capture), .o_count_out(count_out), .o_tc(tc), .o_ovf(ovf),
        .o_capture_out(capture_out), .o_capture_valid(capture_valid)
    );

    multi_counter #(.WIDTH(4), .CHANNELS(2), .SATURATE(1)) dut_sat (
        .clock(clock), .reset(reset), .i_enable(enable), .i_up_down(up_down),
        .i_load(load), .i_load_value(load_value), .i_clear_ovf(clear_ovf),
        .i_capture(capture), .o_count_out(s_count_out), .o_tc(s_tc), .o_ovf(s_ovf),
        .o_capture_out(s_capture_out), .o_capture_valid(s_capture_valid)
    );

    typedef struct {
        string      name;
        logic [1:0] en, ud, ld;
        logic [7:0] lv;
        logic [1:0] clr;
        logic       cap;
        logic [7:0] e_cnt;
        logic [1:0] e_tc, e_ovf;
        logic [7:0] e_cap;
        logic       e_capv;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] en, input logic [1:0] ud,
                         input logic [1:0] ld, input logic [7:0] lv,
                         input logic [1:0] clr, input logic cap);
        reset = rst; enable = en; up_down = ud; load = ld;
        load_value = lv; clear_ovf = clr; capture = cap;
        @(posedge clock);
        #1;
    endtask

    task automatic check_wrap(input string name, input logic [7:0] c, input logic [1:0] t,
                              input logic [1:0] o, input logic [7:0] co, input logic cv);
        check({name, ".count"}, 32'(count_out), 32'(c));
        check({name, ".tc"}, 32'(tc), 32'(t));
        check({name, ".ovf"}, 32'(ovf), 32'(o));
        check({name, ".cap"}, 32'(capture_out), 32'(co));
        check({name, ".capv"}, 32'(capture_valid), 32'(cv));
    endtask

    initial begin
        //           name        en     ud     ld     lv     clr    cap   cnt    tc     ovf    cap    capv
        vecs[0]  = '{"load95",   2'b00, 2'b00, 2'b11, 8'h95, 2'b00, 1'b0, 8'h95, 2'b00, 2'b00, 8'h00, 1'b0};
        vecs[1]  = '{"capture",  2'b11, 2'b11, 2'b00, 8'h00, 2'b00, 1'b1, 8'hA6, 2'b00, 2'b00, 8'h95, 1'b1};
        vecs[2]  = '{"hold",     2'b00, 2'b11, 2'b00, 8'h00, 2'b00, 1'b0, 8'hA6, 2'b00, 2'b00, 8'h95, 1'b0};
        vecs[3]  = '{"loadprio", 2'b11, 2'b11, 2'b10, 8'h30, 2'b00, 1'b0, 8'h37, 2'b00, 2'b00, 8'h95, 1'b0};
        vecs[4]  = '{"down",     2'b11, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0, 8'h26, 2'b00, 2'b00, 8'h95, 1'b0};
        vecs[5]  = '{"mixdir",   2'b11, 2'b01, 2'b00, 8'h00, 2'b00, 1'b0, 8'h17, 2'b00, 2'b00, 8'h95, 1'b0};
        vecs[6]  = '{"loadF",    2'b10, 2'b00, 2'b01, 8'h0F, 2'b00, 1'b0, 8'h0F, 2'b00, 2'b00, 8'h95, 1'b0};
        vecs[7]  = '{"bothwrap", 2'b11, 2'b01, 2'b00, 8'h00, 2'b00, 1'b0, 8'hF0, 2'b11, 2'b11, 8'h95, 1'b0};
        vecs[8]  = '{"clr0",     2'b00, 2'b00, 2'b00, 8'h00, 2'b01, 1'b0, 8'hF0, 2'b00, 2'b10, 8'h95, 1'b0};
        vecs[9]  = '{"dnwrap",   2'b01, 2'b00, 2'b00, 8'h00, 2'b10, 1'b0, 8'hFF, 2'b01, 2'b01, 8'h95, 1'b0};
        vecs[10] = '{"clrvsset", 2'b01, 2'b01, 2'b00, 8'h00, 2'b01, 1'b0, 8'hF0, 2'b01, 2'b01, 8'h95, 1'b0};
        vecs[11] = '{"clronly",  2'b00, 2'b00, 2'b00, 8'h00, 2'b01, 1'b0, 8'hF0, 2'b00, 2'b00, 8'h95, 1'b0};
        vecs[12] = '{"load7",    2'b00, 2'b00, 2'b01, 8'h07, 2'b00, 1'b0, 8'hF7, 2'b00, 2'b00, 8'h95, 1'b0};

        // Reset state
        drive(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
        drive(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
        check_wrap("reset", 8'h00, 2'b00, 2'b00, 8'h00, 1'b0);

        // Full-range up count on both channels
        for (int k = 1; k <= 17; k++) begin
            drive(1'b0, 2'b11, 2'b11, 2'b00, 8'h00, 2'b00, 1'b0);
            check($sformatf("upcnt%0d.count", k), 32'(count_out), 32'({2{4'(k % 16)}}));
            check($sformatf("upcnt%0d.tc", k), 32'(tc), (k == 16) ? 32'h3 : 32'h0);
            check($sformatf("upcnt%0d.ovf", k), 32'(ovf), (k >= 16) ? 32'h3 : 32'h0);
        end

        // Table vectors, starting from a fresh reset
        drive(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, vecs[i].en, vecs[i].ud, vecs[i].ld, vecs[i].lv, vecs[i].clr, vecs[i].cap);
            check_wrap(vecs[i].name, vecs[i].e_cnt, vecs[i].e_tc, vecs[i].e_ovf,
                       vecs[i].e_cap, vecs[i].e_capv);
        end

        // Reset during activity wins over load/enable/capture
        drive(1'b1, 2'b11, 2'b11, 2'b11, 8'hAA, 2'b00, 1'b1);
        check_wrap("midreset", 8'h00, 2'b00, 2'b00, 8'h00, 1'b0);
        drive(1'b0, 2'b11, 2'b11, 2'b00, 8'h00, 2'b00, 1'b0);
        check_wrap("resume", 8'h11, 2'b00, 2'b00, 8'h00, 1'b0);

        // Saturating instance: ch0 down from 2, then ch1 held at MAX
        drive(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
        drive(1'b0, 2'b00, 2'b00, 2'b01, 8'h02, 2'b00, 1'b0);
        check("sat.load", 32'(s_count_out), 32'h02);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 2'b01, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
            check($sformatf("satdn%0d.count", k), 32'(s_count_out), (k == 1) ? 32'h01 : 32'h00);
            check($sformatf("satdn%0d.tc", k), 32'(s_tc), (k >= 3) ? 32'h1 : 32'h0);
            check($sformatf("satdn%0d.ovf", k), 32'(s_ovf), (k >= 3) ? 32'h1 : 32'h0);
        end
        drive(1'b0, 2'b01, 2'b00, 2'b10, 8'hF0, 2'b00, 1'b0);
        check("satld.count", 32'(s_count_out), 32'hF0);
        check("satld.tc", 32'(s_tc), 32'h1);
        for (int k = 1; k <= 2; k++) begin
            drive(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 2'b00, 1'b0);
            check($sformatf("satup%0d.count", k), 32'(s_count_out), 32'hF0);
            check($sformatf("satup%0d.tc", k), 32'(s_tc), 32'h2);
            check($sformatf("satup%0d.ovf", k), 32'(s_ovf), 32'h3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_counter.md
# multi_counter

Parametrised multi-channel synchronous counter bank. It is the successor to the fixed 4-bit dual up-counter, generalised in width and channel count. Each channel adds up/down direction, parallel load, wrap or saturate mode, terminal-count pulses and sticky overflow flags. A coherent snapshot capture lets the CPU datapath and debug logic read all channels from the same cycle.

## Interface
- WIDTH, 4, counter width in bits per channel (≥2)
- CHANNELS, 2, number of independent counter channels (≥1)
- SATURATE, 0, 0 = wrap at range limits; 1 = hold at range limits
- clock  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high; clock clock
- enable  input  CHANNELS  per-channel count enable, active-high
- up_down  input  CHANNELS  per-channel direction: 1 = up, 0 = down
- load  input  CHANNELS  per-channel parallel load, active-high
- load_value  input  CHANNELS*WIDTH  load data; channel i at [i*WIDTH +: WIDTH]
- clear_ovf  input  CHANNELS  per-channel sticky-overflow clear
- capture  input  1  snapshot request for all channels
- count_out  output  CHANNELS*WIDTH  live counter values, registered
- tc  output  CHANNELS  terminal-count pulse, registered, one cycle
- ovf  output  CHANNELS  sticky overflow/underflow flag, registered
- capture_out  output  CHANNELS*WIDTH  snapshot values, registered
- capture_valid  output  1  one-cycle pulse: capture_out updated

## Operation
- Reset: count_out, tc, ovf, capture_out and capture_valid all clear to 0. Reset overrides every other input.
- Per-channel priority at each rising edge: reset > load > enable > hold.
- Load: count ← load_value slice; tc ← 0. The load does not touch ovf.
- Enable, up (up_down=1):
  - count < MAX (2^WIDTH−1): count ← count+1; tc ← 0.
  - count == MAX with SATURATE=0: count ← 0; tc ← 1; ovf ← 1.
  - count == MAX with SATURATE=1: count holds MAX; tc ← 1; ovf ← 1.
- Enable, down (up_down=0):
  - count > 0: count ← count−1; tc ← 0.
  - count == 0 with SATURATE=0: count ← MAX; tc ← 1; ovf ← 1.
  - count == 0 with SATURATE=1: count holds 0; tc ← 1; ovf ← 1.
- Arithmetic is modulo 2^WIDTH with no carry out. Direction may change on any cycle; the new direction takes effect at that edge.
- Enable low (and no load): count holds; tc ← 0.
- ovf clears on clear_ovf=1. If clear_ovf and a new overflow event occur at the same edge, set wins and ovf stays 1.
- Capture: when capture=1 at an edge, capture_out ← count_out as it was before that edge's update, for all channels. capture_valid ← 1 for one cycle. With capture=0, capture_out holds and capture_valid ← 0.
- Channels are fully independent; simultaneous events on different channels never interact.

## Timing
- Load, count, tc, ovf and capture latency is 1 cycle: an input sampled at edge N is visible on the outputs after edge N.
- tc is high for exactly one cycle per wrap/saturate event. With enable held at a saturated limit, tc re-asserts every cycle and ovf stays 1.
- Reset asserted mid-count clears the outputs at the next edge. Counting resumes on the first edge with reset low and enable high.
- No combinational path from any input to any output.

## Test plan
- Reset then enable=2'b11, up: both channels count 0,1,…,15,0. tc pulses in the cycle count_out shows 0 after 15; ovf=1 thereafter.
- SATURATE=1, ch0 down from load_value 2: count_out 2,1,0,0,0. tc is high on each cycle the count shows 0 after a hold attempt (starting with the first edge at 0); ovf=1.
- Load priority: ch1 enable=1, load=1, load_value=4'hA at one edge → count 4'hA, tc 0. ch0 unaffected by the same edge.
- Sticky flag: ch0 wraps (ovf=1), then clear_ovf=1 coincident with a second wrap → ovf stays 1. clear_ovf alone next cycle → ovf 0.
- Capture coherency: ch0=5, ch1=9, both enabled up, capture=1 for one edge → capture_out {9,5}, capture_valid 1 for one cycle, count_out {10,6}.
- Reset mid-operation: reset=1 while ch0=7, enable=1, load=1 → every output 0 after that edge. The load is ignored.
